tm1638_responder: RTL and testbench

Synthesizable TM1638 peripheral model: the responder end of the three-wire STB/CLK/DIO link that the system's display driver initiates. It deserialises command frames into a 16-byte display RAM plus display-control register, and answers key-scan read commands by shifting out 32 bits of key state. It sits beside the system top level, on the same clock and reset as the driver, and is wired back-to-back with it in loopback builds and bench co-simulation.

---
 rtl/tm1638_responder.sv | 186 ++++++++++++++++++
 tb/tb_tm1638_responder.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tm1638_responder.sv
// TM1638 responder: STB/CLK/DIO deserialiser, 16-byte display RAM, key-scan readout.
// Key-read path is built only when TM1638_KEY_READ_EN is defined.
module tm1638_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tm_stb,
  input  logic        tm_clk,
  input  logic        tm_dio_in,
  output logic        tm_dio_out,
  output logic        tm_dio_oe,
  input  logic [31:0] keys,
  input  logic [3:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic        ram_wr,
  output logic        disp_on,
  output logic [2:0]  brightness
);

  typedef enum logic [2:0] {
    IDLE, CMD, WRITE, READ, SKIP
  } state_t;

  logic [SYNC_STAGES-1:0] stb_sync;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dio_sync;
  logic stb_s, clk_s, dio_s;
  logic stb_d, clk_d;
  logic stb_fall;
  logic clk_rise, clk_fall;

  // Chains reset low so a strobe held low across reset never fakes a frame start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stb_sync <= '0;
      clk_sync <= '0;
      dio_sync <= '0;
      stb_d    <= 1'b0;
      clk_d    <= 1'b0;
    end else begin
      stb_sync <= {stb_sync[SYNC_STAGES-2:0], tm_stb};
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], tm_clk};
      dio_sync <= {dio_sync[SYNC_STAGES-2:0], tm_dio_in};
      stb_d    <= stb_s;
      clk_d    <= clk_s;
    end
  end

  assign stb_s    = stb_sync[SYNC_STAGES-1];
  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign dio_s    = dio_sync[SYNC_STAGES-1];
  assign stb_fall = ~stb_s & stb_d;
  assign clk_rise = clk_s & ~clk_d;
  assign clk_fall = ~clk_s & clk_d;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [6:0] shreg;
  logic [7:0] rx_byte;
  logic [3:0] ptr;
  logic       fixed_addr;
  logic [7:0] ram [16];

  assign rx_byte = {dio_s, shreg};

`ifdef TM1638_KEY_READ_EN
  logic        read_mode;
  logic [31:0] key_sh;
  logic [5:0]  key_cnt;
`else
  logic unused_keys;
  assign unused_keys = ^keys;
  assign tm_dio_out  = 1'b0;
  assign tm_dio_oe   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      ptr        <= '0;
      fixed_addr <= 1'b0;
      ram_wr     <= 1'b0;
      rd_data    <= '0;
      disp_on    <= 1'b0;
      brightness <= '0;
      for (int i = 0; i < 16; i++) ram[i] <= '0;
`ifdef TM1638_KEY_READ_EN
      read_mode  <= 1'b0;
      key_sh     <= '0;
      key_cnt    <= '0;
      tm_dio_out <= 1'b0;
      tm_dio_oe  <= 1'b0;
`endif
    end else begin
      ram_wr  <= 1'b0;
      rd_data <= ram[rd_addr];
      if (stb_s) begin
        // Strobe high wins over any same-cycle clock edge.
        state   <= IDLE;
        bit_cnt <= '0;
`ifdef TM1638_KEY_READ_EN
        tm_dio_oe  <= 1'b0;
        tm_dio_out <= 1'b0;
`endif
      end else begin
        unique case (state)
          IDLE: begin
            if (stb_fall) begin
              state   <= CMD;
              bit_cnt <= '0;
            end
          end
          CMD: begin
            if (clk_rise) begin
              shreg   <= {dio_s, shreg[6:1]};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                unique case (rx_byte[7:6])
                  2'b01: begin
`ifdef TM1638_KEY_READ_EN
                    read_mode  <= rx_byte[1];
                    fixed_addr <= rx_byte[2];
                    if (rx_byte[1]) begin
                      state   <= READ;
                      key_sh  <= keys;
                      key_cnt <= '0;
                    end else begin
                      state <= SKIP;
                    end
`else
                    if (!rx_byte[1]) fixed_addr <= rx_byte[2];
                    state <= SKIP;
`endif
                  end
                  2'b11: begin
                    ptr   <= rx_byte[3:0];
                    state <= WRITE;
                  end
                  2'b10: begin
                    disp_on    <= rx_byte[3];
                    brightness <= rx_byte[2:0];
                    state      <= SKIP;
                  end
                  default: state <= SKIP;
                endcase
              end
            end
          end
          WRITE: begin
            if (clk_rise) begin
              shreg   <= {dio_s, shreg[6:1]};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                ram[ptr] <= rx_byte;
                ram_wr   <= 1'b1;
                if (!fixed_addr) ptr <= ptr + 4'd1;
              end
            end
          end
          READ: begin
`ifdef TM1638_KEY_READ_EN
            if (clk_fall && read_mode) begin
              if (key_cnt < 6'd32) begin
                tm_dio_oe  <= 1'b1;
                tm_dio_out <= key_sh[0];
                key_sh     <= {1'b0, key_sh[31:1]};
                key_cnt    <= key_cnt + 6'd1;
              end else if (key_cnt == 6'd32) begin
                tm_dio_oe  <= 1'b0;
                tm_dio_out <= 1'b0;
                key_cnt    <= 6'd33;
              end
            end
`endif
          end
          SKIP: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tm1638_responder.sv
// Directed bench for tm1638_responder: bit-banged STB/CLK/DIO frames.
// Key-read expectations follow TM1638_KEY_READ_EN.
module tb_tm1638_responder;

  logic        clk;
  logic        rst;
  logic        tm_stb;
  logic        tm_clk;
  logic        tm_dio_in;
  logic        tm_dio_out;
  logic        tm_dio_oe;
  logic [31:0] keys;
  logic [3:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        ram_wr;
  logic        disp_on;
  logic [2:0]  brightness;

  int pass_cnt = 0;
  int total_cnt = 0;
  int wr_cnt = 0;
  logic oe_seen = 1'b0;

  localparam int HP = 8;

  tm1638_responder #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .tm_stb     (tm_stb),
    .tm_clk     (tm_clk),
    .tm_dio_in  (tm_dio_in),
    .tm_dio_out (tm_dio_out),
    .tm_dio_oe  (tm_dio_oe),
    .keys       (keys),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .ram_wr     (ram_wr),
    .disp_on    (disp_on),
    .brightness (brightness)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr === 1'b1) wr_cnt <= wr_cnt + 1;
    if (tm_dio_oe === 1'b1) oe_seen <= 1'b1;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      tm_clk = 1'b0;
      tm_dio_in = b[i];
      wait_clks(HP);
      tm_clk = 1'b1;
      wait_clks(HP);
    end
  endtask

  task automatic frame_begin();
    tm_stb = 1'b0;
    wait_clks(HP);
  endtask

  task automatic frame_end();
    tm_stb = 1'b1;
    wait_clks(HP);
  endtask

  task automatic frame1(input logic [7:0] b0);
    frame_begin();
    send_bits(b0, 8);
    frame_end();
  endtask

  task automatic read_ram(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst = 1'b0;
    wait_clks(4);
    total_cnt++;
    if ({tm_dio_out, tm_dio_oe, ram_wr, disp_on, brightness, rd_data} !== 14'd0) begin
      $display("FAIL reset_outputs got=%b want=0",
        {tm_dio_out, tm_dio_oe, ram_wr, disp_on, brightness, rd_data});
    end else pass_cnt++;
    rst = 1'b1;
    wait_clks(4);
    read_ram(4'd9, d);
    total_cnt++;
    if (d !== 8'h00) $display("FAIL reset_ram9 got=%h want=00", d);
    else pass_cnt++;
  endtask

  task automatic test_disp_ctrl();
    frame1(8'h8B);
    total_cnt++;
    if ({disp_on, brightness} !== 4'b1011) begin
      $display("FAIL disp_8b got=%b want=1011", {disp_on, brightness});
    end else pass_cnt++;
    frame1(8'h84);
    total_cnt++;
    if ({disp_on, brightness} !== 4'b0100) begin
      $display("FAIL disp_84 got=%b want=0100", {disp_on, brightness});
    end else pass_cnt++;
  endtask

  task automatic test_ignored_cmd();
    int w0;
    w0 = wr_cnt;
    frame_begin();
    send_bits(8'h0F, 8);
    send_bits(8'h5A, 8);
    frame_end();
    total_cnt++;
    if (wr_cnt - w0 !== 0 || {disp_on, brightness} !== 4'b0100) begin
      $display("FAIL ignored_cmd got wr=%0d disp=%b want wr=0 disp=0100",
        wr_cnt - w0, {disp_on, brightness});
    end else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    frame_begin();
    send_bits(8'hC2, 8);
    send_bits(8'h99, 8);
    frame_end();
    read_ram(4'd2, d);
    total_cnt++;
    if (d !== 8'h99) $display("FAIL pre_reset_ram2 got=%h want=99", d);
    else pass_cnt++;
    frame1(8'h8A);
    frame_begin();
    send_bits(8'h8F, 4);
    rst = 1'b0;
    wait_clks(3);
    total_cnt++;
    if ({tm_dio_oe, ram_wr, disp_on, brightness} !== 6'd0) begin
      $display("FAIL midreset_outputs got=%b want=0",
        {tm_dio_oe, ram_wr, disp_on, brightness});
    end else pass_cnt++;
    rst = 1'b1;
    wait_clks(3);
    send_bits(8'h8F, 8);
    total_cnt++;
    if (disp_on !== 1'b0) $display("FAIL midreset_discard got=%b want=0", disp_on);
    else pass_cnt++;
    frame_end();
    read_ram(4'd2, d);
    total_cnt++;
    if (d !== 8'h00) $display("FAIL midreset_ram2 got=%h want=00", d);
    else pass_cnt++;
    frame1(8'h8F);
    total_cnt++;
    if ({disp_on, brightness} !== 4'b1111) begin
      $display("FAIL after_reset_8f got=%b want=1111", {disp_on, brightness});
    end else pass_cnt++;
  endtask

  task automatic test_auto_inc();
    logic [7:0] d;
    int w0;
    frame1(8'h40);
    w0 = wr_cnt;
    frame_begin();
    send_bits(8'hCE, 8);
    send_bits(8'h11, 8);
    send_bits(8'h22, 8);
    send_bits(8'h33, 8);
    frame_end();
    total_cnt++;
    if (wr_cnt - w0 !== 3) $display("FAIL autoinc_pulses got=%0d want=3", wr_cnt - w0);
    else pass_cnt++;
    read_ram(4'd14, d);
    total_cnt++;
    if (d !== 8'h11) $display("FAIL autoinc_ram14 got=%h want=11", d);
    else pass_cnt++;
    read_ram(4'd15, d);
    total_cnt++;
    if (d !== 8'h22) $display("FAIL autoinc_ram15 got=%h want=22", d);
    else pass_cnt++;
    read_ram(4'd0, d);
    total_cnt++;
    if (d !== 8'h33) $display("FAIL autoinc_wrap_ram0 got=%h want=33", d);
    else pass_cnt++;
    read_ram(4'd1, d);
    total_cnt++;
    if (d !== 8'h00) $display("FAIL autoinc_ram1 got=%h want=00", d);
    else pass_cnt++;
  endtask

  task automatic test_fixed_addr();
    logic [7:0] d;
    int w0;
    frame1(8'h44);
    w0 = wr_cnt;
    frame_begin();
    send_bits(8'hC3, 8);
    send_bits(8'hAA, 8);
    send_bits(8'h55, 8);
    frame_end();
    total_cnt++;
    if (wr_cnt - w0 !== 2) $display("FAIL fixed_pulses got=%0d want=2", wr_cnt - w0);
    else pass_cnt++;
    read_ram(4'd3, d);
    total_cnt++;
    if (d !== 8'h55) $display("FAIL fixed_ram3 got=%h want=55", d);
    else pass_cnt++;
    read_ram(4'd4, d);
    total_cnt++;
    if (d !== 8'h00) $display("FAIL fixed_ram4 got=%h want=00", d);
    else pass_cnt++;
    frame1(8'h40);
  endtask

  task automatic test_key_read();
    logic [31:0] want;
    logic [31:0] got;
    logic        oe_all;
    want = 32'hA5C3_0F81;
    keys = want;
    got = '0;
    oe_all = 1'b1;
    oe_seen = 1'b0;
    frame_begin();
    send_bits(8'h42, 8);
    for (int i = 0; i < 32; i++) begin
      tm_clk = 1'b0;
      wait_clks(HP);
      got[i] = tm_dio_out;
      if (tm_dio_oe !== 1'b1) oe_all = 1'b0;
      tm_clk = 1'b1;
      wait_clks(HP);
    end
    tm_clk = 1'b0;
    wait_clks(HP);
`ifdef TM1638_KEY_READ_EN
    total_cnt++;
    if (got !== want) $display("FAIL key_data got=%h want=%h", got, want);
    else pass_cnt++;
    total_cnt++;
    if (oe_all !== 1'b1) $display("FAIL key_oe_during got=0 want=1");
    else pass_cnt++;
    total_cnt++;
    if (tm_dio_oe !== 1'b0) $display("FAIL key_oe_after got=%b want=0", tm_dio_oe);
    else pass_cnt++;
`else
    total_cnt++;
    if (oe_seen !== 1'b0) $display("FAIL key_oe_disabled got=%b want=0", oe_seen);
    else pass_cnt++;
    total_cnt++;
    if (got !== 32'd0) $display("FAIL key_dout_disabled got=%h want=0", got);
    else pass_cnt++;
`endif
    tm_clk = 1'b1;
    wait_clks(HP);
    frame_end();
    total_cnt++;
    if (tm_dio_oe !== 1'b0) $display("FAIL key_oe_idle got=%b want=0", tm_dio_oe);
    else pass_cnt++;
  endtask

  task automatic test_aborted_byte();
    logic [7:0] d;
    int w0;
    w0 = wr_cnt;
    frame_begin();
    send_bits(8'hC5, 8);
    send_bits(8'h7E, 8);
    send_bits(8'hFF, 5);
    frame_end();
    total_cnt++;
    if (wr_cnt - w0 !== 1) $display("FAIL abort_pulses got=%0d want=1", wr_cnt - w0);
    else pass_cnt++;
    read_ram(4'd5, d);
    total_cnt++;
    if (d !== 8'h7E) $display("FAIL abort_ram5 got=%h want=7e", d);
    else pass_cnt++;
    read_ram(4'd6, d);
    total_cnt++;
    if (d !== 8'h00) $display("FAIL abort_ram6 got=%h want=00", d);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b0;
    tm_stb = 1'b1;
    tm_clk = 1'b1;
    tm_dio_in = 1'b0;
    keys = '0;
    rd_addr = '0;
    test_reset();
    test_disp_ctrl();
    test_ignored_cmd();
    test_reset_mid_frame();
    test_auto_inc();
    test_fixed_addr();
    test_key_read();
    test_aborted_byte();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
